baud_gen_frac: RTL and testbench
================================

Name: baud_gen_frac

Overview:
Next-generation UART baud-tick source. It replaces the fixed integer divider with a runtime-programmable fractional divider (integer plus fractional part) and produces two tick streams. rx_tick runs at OVERSAMPLE x baud for the receiver sampler; tx_tick runs at 1x baud for the transmitter. It sits between the system clock and the UART TX/RX FSMs. It adds enable, phase restart for start-bit alignment, and a valid/ready config port with glitch-free divisor switching at bit boundaries.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz.
DEFAULT_BAUD, 2400, baud rate loaded at reset.
OVERSAMPLE, 16, rx_tick per tx_tick; must be ≥ 2.
DIV_W, 16, width of the integer divisor.
FRAC_W, 8, width of the fractional divisor and of the accumulator.

Ports:
clk  in  1  system clock
srst_n  in  1  asynchronous, active-low reset
en  in  1  1 = run; 0 = freeze all counters, no ticks
restart  in  1  single-cycle pulse that realigns phase (RX start-bit detect)
cfg_valid  in  1  new divisor offered
cfg_ready  out  1  divisor can be accepted (no apply pending)
cfg_div_int  in  DIV_W  integer cycles per rx_tick
cfg_div_frac  in  FRAC_W  fractional cycles per rx_tick, in units of 1/2^FRAC_W
rx_tick  out  1  one-cycle pulse at OVERSAMPLE x baud
tx_tick  out  1  one-cycle pulse at 1x baud; always coincides with an rx_tick
cfg_pending  out  1  accepted divisor not yet applied

Behaviour:
- Reset (async assert, sync release):
  - cnt = 0, acc = 0, carry = 0, os_cnt = 0.
  - rx_tick, tx_tick and cfg_pending = 0; cfg_ready = 1.
  - Active divisor = package defaults: div_int = floor(CLK_FREQ/(DEFAULT_BAUD*OVERSAMPLE)); div_frac = floor(remainder*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE)). With the default parameters this gives 26 and 10.
- Period: each rx_tick interval is P = div_int + carry cycles.
  - cnt counts 0..P-1.
  - rx_tick is registered; it is high in the cycle in which cnt wraps from P-1 to 0.
  - The first rx_tick after reset release or restart (en = 1) is exactly div_int cycles later.
- Fraction: on every rx_tick, {carry, acc} <= acc + div_frac, computed FRAC_W+1 bits wide. carry lengthens the next period only.
- Oversample: os_cnt increments on each rx_tick and wraps OVERSAMPLE-1 -> 0. tx_tick = rx_tick AND (os_cnt == OVERSAMPLE-1).
- en = 0: cnt, acc, carry and os_cnt hold their values, and both ticks are 0. Counting resumes seamlessly when en returns to 1.
- restart = 1: cnt, acc, carry and os_cnt clear to 0; no tick in that cycle. restart overrides a tick due in the same cycle.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready at the clock edge. The values are latched into a shadow register; cfg_pending goes to 1 and cfg_ready = !cfg_pending.
  - cfg_valid while pending is ignored and the master holds it.
  - cfg_div_int < 2 is clamped to 2 when latched.
- Apply:
  - The shadow copies to the active divisor in the cycle of the next tx_tick, or the next restart, or immediately in the next cycle if en = 0.
  - On apply: acc and carry clear, and cfg_pending drops to 0 in the same edge.
  - The period after the applying tick uses the new div_int.
  - No partial-bit period mixes old and new divisors.
- Simultaneous restart and apply: both take effect in the same edge.
- Async reset mid-operation discards any pending config.

Decomposition:
- Package baud_pkg holds:
  - typedef div_cfg_t: a packed struct {logic [DIV_W-1:0] int_part; logic [FRAC_W-1:0] frac_part}.
  - function default_div(CLK_FREQ, BAUD, OVERSAMPLE), returning div_cfg_t.
  - localparam MIN_DIV = 2.
- One sub-module, frac_tick_div: cnt, acc and carry, with inputs en, clear, and active div_cfg_t, and output rx_tick.
- The top level holds os_cnt, the shadow register, the handshake and the apply logic.

Test Plan:
- Reset defaults: release srst_n with en = 1, run 256 rx_ticks. Required: first rx_tick at cycle 26; total span 256*26 + 10 = 6666 cycles; tx_tick on every 16th rx_tick.
- Integer divisor: program int = 4, frac = 0 while en = 0. Required: applied next cycle; cfg_ready returns to 1; then rx_tick every 4 cycles and tx_tick every 64.
- Fraction: int = 4, frac = 128. Required: periods alternate 4, 5, 4, 5; 16 rx_ticks span 72 cycles.
- Switch during run: from int = 4, accept int = 6 mid-bit. Required: cfg_pending = 1 and cfg_ready = 0 until the next tx_tick; rx_tick spacing stays 4 through that tick, then becomes 6. A second cfg_valid offered during pending is not accepted.
- Restart / en: pulse restart 2 cycles before a tick is due. Required: no tick then; next rx_tick div_int cycles after restart; os_cnt = 0 (tx_tick after 16 rx_ticks). Drop en for 10 cycles: no ticks, phase resumes unchanged.
- Clamp and async reset: cfg_div_int = 1 gives rx_tick every 2 cycles. Assert srst_n low mid-period with a config pending: all outputs 0 immediately, cfg_ready = 1, defaults restored.

Source files
------------

// File: rtl/baud_pkg.sv
// baud_pkg: shared types and helpers for the fractional baud-tick generator.
//   DIV_W / FRAC_W : widths of the integer and fractional divisor parts.
//   MIN_DIV        : smallest integer divisor the generator will run with.
//   div_cfg_t      : {int_part, frac_part} divisor, period = int + frac/2^FRAC_W.
//   default_div()  : divisor for a given clock, baud rate and oversample ratio.
package baud_pkg;

  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 8;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [DIV_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
  } div_cfg_t;

  // Integer part is the truncated quotient; the remainder is scaled to
  // 1/2^FRAC_W units and truncated as well.
  function automatic div_cfg_t default_div(input longint clk_freq,
                                           input longint baud,
                                           input longint oversample);
    longint   den;
    longint   q;
    longint   r;
    div_cfg_t d;
    den         = baud * oversample;
    q           = clk_freq / den;
    r           = clk_freq % den;
    d.int_part  = DIV_W'(q);
    d.frac_part = FRAC_W'((r << FRAC_W) / den);
    return d;
  endfunction

endpackage

// File: rtl/baud_gen_frac_div.sv
// frac_tick_div: fractional cycle divider producing the oversampled tick.
//   clk, srst_n : clock, asynchronous active-low reset
//   en          : 1 = count, 0 = hold cnt/acc/carry and suppress ticks
//   clear       : realign phase (cnt, acc, carry -> 0), no tick this cycle
//   clr_frac    : clear only the fractional accumulator (divisor switch)
//   div         : active divisor
//   tick_due    : combinational, a tick is generated at this edge
//   rx_tick     : registered one-cycle tick
module frac_tick_div
  import baud_pkg::*;
(
  input  logic     clk,
  input  logic     srst_n,
  input  logic     en,
  input  logic     clear,
  input  logic     clr_frac,
  input  div_cfg_t div,
  output logic     tick_due,
  output logic     rx_tick
);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W:0]    period;
  logic [DIV_W:0]    cnt_nx;
  logic [FRAC_W:0]   frac_sum;

  assign period   = {1'b0, div.int_part} + {{DIV_W{1'b0}}, carry};
  assign cnt_nx   = {1'b0, cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign frac_sum = {1'b0, acc} + {1'b0, div.frac_part};

  // >= rather than == so a count held above a freshly shortened period
  // (divisor applied while frozen) still wraps on the next enabled edge.
  assign tick_due = en & ~clear & (cnt_nx >= period);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      cnt     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      rx_tick <= 1'b0;
    end else begin
      rx_tick <= tick_due;
      if (clear) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= tick_due ? '0 : cnt + DIV_W'(1);
      end
      // carry out of the accumulator stretches only the following period
      if (clear || clr_frac) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (tick_due) begin
        {carry, acc} <= frac_sum;
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable fractional UART baud-tick source.
//   clk, srst_n  : clock, asynchronous active-low reset
//   en           : 1 = run, 0 = freeze counters, no ticks
//   restart      : one-cycle phase realign (start-bit detect)
//   cfg_valid/cfg_ready, cfg_div_int, cfg_div_frac : divisor offer handshake
//   rx_tick      : OVERSAMPLE x baud tick
//   tx_tick      : 1x baud tick, coincident with an rx_tick
//   cfg_pending  : accepted divisor waiting to be applied
// A new divisor is held in a shadow copy and switched in only on a bit
// boundary (tx tick), a restart, or while frozen, so no bit mixes divisors.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ     = 1000000,
  parameter int DEFAULT_BAUD = 2400,
  parameter int OVERSAMPLE   = 16
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              en,
  input  logic              restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              rx_tick,
  output logic              tx_tick,
  output logic              cfg_pending
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam div_cfg_t        DEF_DIV = default_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE);

  function automatic div_cfg_t clamp_cfg(input logic [DIV_W-1:0]  i,
                                         input logic [FRAC_W-1:0] f);
    div_cfg_t c;
    c.int_part  = (i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i;
    c.frac_part = f;
    return c;
  endfunction

  div_cfg_t        active;
  div_cfg_t        shadow;
  logic [OS_W-1:0] os_cnt;
  logic            tick_due;
  logic            tx_due;
  logic            apply;
  logic            accept;

  assign tx_due    = tick_due & (os_cnt == OS_LAST);
  assign apply     = cfg_pending & (tx_due | restart | ~en);
  assign cfg_ready = ~cfg_pending;
  assign accept    = cfg_valid & cfg_ready;

  frac_tick_div u_div (
    .clk      (clk),
    .srst_n   (srst_n),
    .en       (en),
    .clear    (restart),
    .clr_frac (apply),
    .div      (active),
    .tick_due (tick_due),
    .rx_tick  (rx_tick)
  );

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      os_cnt      <= '0;
      tx_tick     <= 1'b0;
      cfg_pending <= 1'b0;
      active      <= DEF_DIV;
      shadow      <= DEF_DIV;
    end else begin
      tx_tick <= tx_due;
      if (restart) begin
        os_cnt <= '0;
      end else if (tick_due) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end
      // apply and accept are exclusive: accept needs cfg_pending low
      if (apply) begin
        active      <= shadow;
        cfg_pending <= 1'b0;
      end
      if (accept) begin
        shadow      <= clamp_cfg(cfg_div_int, cfg_div_frac);
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;
  import baud_pkg::*;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 2400;
  localparam int OS       = 16;

  logic              clk = 1'b0;
  logic              srst_n = 1'b0;
  logic              en = 1'b0;
  logic              restart = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [DIV_W-1:0]  cfg_div_int = '0;
  logic [FRAC_W-1:0] cfg_div_frac = '0;
  logic              cfg_ready;
  logic              rx_tick;
  logic              tx_tick;
  logic              cfg_pending;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rxq[$];
  int txq[$];

  // behavioural model state
  int m_int, m_frac, s_int, s_frac;
  int ph, extra, n_frac, n_os;
  bit m_pend = 1'b0, m_rx = 1'b0, m_tx = 1'b0;

  baud_gen_frac #(
    .CLK_FREQ    (CLK_FREQ),
    .DEFAULT_BAUD(BAUD),
    .OVERSAMPLE  (OS)
  ) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .en          (en),
    .restart     (restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div_int (cfg_div_int),
    .cfg_div_frac(cfg_div_frac),
    .rx_tick     (rx_tick),
    .tx_tick     (tx_tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a period is the integer divisor plus the extra cycle owed by the
  // running fraction total n*frac/256 crossing an integer since the last clear.
  always @(posedge clk) begin : model
    bit due, txd, app, take;
    if (!srst_n) begin
      cyc    = 0;
      m_int  = CLK_FREQ / (BAUD * OS);
      m_frac = ((CLK_FREQ % (BAUD * OS)) * 256) / (BAUD * OS);
      s_int  = m_int;
      s_frac = m_frac;
      ph = 0; extra = 0; n_frac = 0; n_os = 0;
      m_pend = 0; m_rx = 0; m_tx = 0;
    end else begin
      cyc++;
      due  = en && !restart && (ph + 1 >= m_int + extra);
      txd  = due && ((n_os % OS) == OS - 1);
      app  = m_pend && (txd || restart || !en);
      take = cfg_valid && !m_pend;
      m_rx = due;
      m_tx = txd;
      if (restart) begin
        ph = 0; n_os = 0; n_frac = 0; extra = 0;
      end else if (en) begin
        if (due) begin
          ph = 0;
          n_os++;
          n_frac++;
          extra = (n_frac * m_frac) / 256 - ((n_frac - 1) * m_frac) / 256;
        end else begin
          ph++;
        end
      end
      if (app) begin
        m_int = s_int; m_frac = s_frac; n_frac = 0; extra = 0; m_pend = 0;
      end
      if (take) begin
        s_int  = (cfg_div_int < 2) ? 2 : int'(cfg_div_int);
        s_frac = int'(cfg_div_frac);
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!srst_n) begin
      check("rst_rx_tick", rx_tick, 0);
      check("rst_tx_tick", tx_tick, 0);
      check("rst_cfg_pending", cfg_pending, 0);
      check("rst_cfg_ready", cfg_ready, 1);
    end else begin
      check("rx_tick", rx_tick, m_rx);
      check("tx_tick", tx_tick, m_tx);
      check("cfg_pending", cfg_pending, m_pend);
      check("cfg_ready", cfg_ready, !m_pend);
      if (rx_tick) rxq.push_back(cyc);
      if (tx_tick) txq.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      step();
      k++;
    end
    check("wait_rx_budget", rxq.size() >= n, 1);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      step();
      k++;
    end
    check("wait_tx_budget", txq.size() >= n, 1);
  endtask

  // program a divisor while frozen: accepted on one edge, applied on the next
  task automatic load_frozen(input int i, input int f);
    en           = 1'b0;
    cfg_valid    = 1'b1;
    cfg_div_int  = DIV_W'(i);
    cfg_div_frac = FRAC_W'(f);
    step();
    cfg_valid = 1'b0;
    step();
    en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, idx, c, ta, rs;

    // reset defaults
    en = 1'b1;
    repeat (3) step();
    check("reset_rx", rx_tick, 0);
    check("reset_pending", cfg_pending, 0);
    check("reset_ready", cfg_ready, 1);
    srst_n = 1'b1;
    wait_rx(257, 7200);
    check("first_rx_cycle", rxq[0], 26);
    check("span_256_periods", rxq[256] - rxq[0], 6666);
    check("first_tx_on_16th_rx", txq[0], rxq[15]);
    c = 0;
    foreach (txq[j]) if (txq[j] <= rxq[255]) c++;
    check("tx_count_in_256_rx", c, 16);

    // integer divisor programmed while frozen
    en           = 1'b0;
    cfg_valid    = 1'b1;
    cfg_div_int  = DIV_W'(4);
    cfg_div_frac = '0;
    step();
    check("int4_pending_after_accept", cfg_pending, 1);
    check("int4_ready_after_accept", cfg_ready, 0);
    cfg_valid = 1'b0;
    step();
    check("int4_pending_after_apply", cfg_pending, 0);
    check("int4_ready_after_apply", cfg_ready, 1);
    en = 1'b1;
    rxq.delete(); txq.delete();
    wait_rx(20, 200);
    check("int4_rx_gap_a", rxq[2] - rxq[1], 4);
    check("int4_rx_gap_b", rxq[19] - rxq[18], 4);
    wait_tx(2, 300);
    check("int4_tx_gap", txq[1] - txq[0], 64);

    // fractional divisor 4 + 128/256
    load_frozen(4, 128);
    rxq.delete(); txq.delete();
    wait_rx(17, 200);
    check("frac_gap_first", rxq[1] - rxq[0], 4);
    check("frac_gap_second", rxq[2] - rxq[1], 5);
    check("frac_span_16", rxq[16] - rxq[0], 72);

    // switch 4 -> 6 mid-bit, with a second offer held during pending
    load_frozen(4, 0);
    rxq.delete(); txq.delete();
    wait_tx(1, 200);
    wait_rx(rxq.size() + 2, 50);
    txq.delete();
    cfg_valid    = 1'b1;
    cfg_div_int  = DIV_W'(6);
    cfg_div_frac = '0;
    step();
    check("switch_pending", cfg_pending, 1);
    check("switch_ready", cfg_ready, 0);
    cfg_div_int = DIV_W'(9);
    c = 0;
    while (cfg_pending && c < 200) begin
      step();
      c++;
    end
    cfg_valid = 1'b0;
    check("switch_applied_on_tx", txq.size(), 1);
    t   = (txq.size() > 0) ? txq[0] : -1;
    idx = -1;
    foreach (rxq[j]) if (rxq[j] == t) idx = j;
    check("switch_tick_found", idx >= 1, 1);
    if (idx < 1) idx = 1;
    wait_rx(idx + 3, 50);
    check("switch_old_gap", rxq[idx] - rxq[idx-1], 4);
    check("switch_new_gap_a", rxq[idx+1] - rxq[idx], 6);
    check("switch_new_gap_b", rxq[idx+2] - rxq[idx+1], 6);

    // restart two cycles before a tick is due
    rxq.delete();
    wait_rx(1, 50);
    repeat (3) step();
    restart = 1'b1;
    rs      = cyc + 1;
    step();
    restart = 1'b0;
    rxq.delete(); txq.delete();
    wait_rx(16, 200);
    check("restart_first_rx", rxq[0], rs + 6);
    check("restart_tx_on_16th", txq.size() > 0 ? txq[0] : -1, rxq[15]);

    // freeze for 10 cycles mid-period
    rxq.delete();
    wait_rx(1, 50);
    ta = rxq[0];
    step();
    step();
    en = 1'b0;
    repeat (10) step();
    check("freeze_no_ticks", rxq.size(), 1);
    en = 1'b1;
    wait_rx(2, 50);
    check("freeze_resume_gap", rxq[1] - ta, 16);

    // divisor 1 is clamped to 2
    load_frozen(1, 0);
    rxq.delete();
    wait_rx(6, 50);
    check("clamp_gap_a", rxq[2] - rxq[1], 2);
    check("clamp_gap_b", rxq[5] - rxq[4], 2);

    // async reset with a config pending
    txq.delete();
    wait_tx(1, 100);
    cfg_valid   = 1'b1;
    cfg_div_int = DIV_W'(7);
    step();
    cfg_valid = 1'b0;
    check("areset_pending_before", cfg_pending, 1);
    repeat (3) step();
    #2;
    srst_n = 1'b0;
    #1;
    check("areset_rx", rx_tick, 0);
    check("areset_tx", tx_tick, 0);
    check("areset_pending", cfg_pending, 0);
    check("areset_ready", cfg_ready, 1);
    step();
    step();
    srst_n = 1'b1;
    rxq.delete(); txq.delete();
    wait_rx(2, 100);
    check("areset_first_rx", rxq[0], 26);
    check("areset_default_gap", rxq[1] - rxq[0], 26);
    check("areset_pending_after", cfg_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
